// File: rtl/write_through_buffer_pkg.sv
// Shared types and entry-layout helpers for the write-through buffer.
// Entry word layout, MSB to LSB: {word address, data, byte strobe}.
package write_through_buffer_pkg;

    // Drain FSM encoding: IDLE=0, WRITE=1.
    typedef enum logic {
        StIdle  = 1'b0,
        StWrite = 1'b1
    } wtbuf_state_e;

    function automatic int unsigned wtbuf_strb_w(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Strobe occupies the low bits, so data starts right above it.
    function automatic int unsigned wtbuf_data_lsb(input int unsigned data_w);
        return wtbuf_strb_w(data_w);
    endfunction

    function automatic int unsigned wtbuf_addr_lsb(input int unsigned data_w);
        return wtbuf_strb_w(data_w) + data_w;
    endfunction

    function automatic int unsigned wtbuf_entry_w(input int unsigned addr_w,
                                                  input int unsigned data_w);
        return (addr_w - 2) + data_w + wtbuf_strb_w(data_w);
    endfunction

endpackage

// File: rtl/write_through_buffer_fifo_mem.sv
// Register-array storage for the write-through buffer: one synchronous write port
// and one asynchronous read port. Pointers and occupancy live in the parent.
module write_through_buffer_fifo_mem #(
    parameter int unsigned DEPTH_W = 4,
    parameter int unsigned ENTRY_W = 68
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [DEPTH_W-1:0] wr_ptr,
    input  logic [ENTRY_W-1:0] wr_entry,
    input  logic [DEPTH_W-1:0] rd_ptr,
    output logic [ENTRY_W-1:0] rd_entry
);

    logic [ENTRY_W-1:0] mem_q [2**DEPTH_W];

    // Storage write; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr] <= wr_entry;
        end
    end

    assign rd_entry = mem_q[rd_ptr];

endmodule

// File: rtl/write_through_buffer.sv
// Write-through buffer: queues front-end writes and drains them in order to a
// valid/ready back-end port. Optional write coalescing into the tail entry is
// enabled by defining WTBUF_COALESCE_EN.
module write_through_buffer
    import write_through_buffer_pkg::*;
#(
    parameter int unsigned FE_ADDR_W     = 32,
    parameter int unsigned FE_DATA_W     = 32,
    parameter int unsigned WTBUF_DEPTH_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  logic [FE_ADDR_W-3:0]     wr_addr,
    input  logic [FE_DATA_W-1:0]     wr_wdata,
    input  logic [FE_DATA_W/8-1:0]   wr_wstrb,
    output logic                     wr_ready,
    output logic                     mem_valid,
    output logic [FE_ADDR_W-1:0]     mem_addr,
    output logic [FE_DATA_W-1:0]     mem_wdata,
    output logic [FE_DATA_W/8-1:0]   mem_wstrb,
    input  logic                     mem_ready,
    output logic                     full,
    output logic                     empty,
    output logic [WTBUF_DEPTH_W:0]   level
);

    localparam int unsigned WordW   = FE_ADDR_W - 2;
    localparam int unsigned StrbW   = wtbuf_strb_w(FE_DATA_W);
    localparam int unsigned EntryW  = wtbuf_entry_w(FE_ADDR_W, FE_DATA_W);
    localparam int unsigned DataLsb = wtbuf_data_lsb(FE_DATA_W);
    localparam int unsigned AddrLsb = wtbuf_addr_lsb(FE_DATA_W);
    localparam int unsigned LevelW  = WTBUF_DEPTH_W + 1;
    localparam logic [LevelW-1:0] FullLevel = LevelW'(1) << WTBUF_DEPTH_W;

    wtbuf_state_e             state_q, state_d;
    logic [WTBUF_DEPTH_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LevelW-1:0]        level_q, level_d;
    logic                     full_q, full_d, empty_q, empty_d;
    logic                     mem_valid_q, mem_valid_d;
    logic [WordW-1:0]         mem_waddr_q, mem_waddr_d;
    logic [FE_DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic [StrbW-1:0]         mem_wstrb_q, mem_wstrb_d;

    logic                     pop, alloc, merge;
    logic                     ram_we;
    logic [WTBUF_DEPTH_W-1:0] ram_wptr;
    logic [EntryW-1:0]        ram_wentry, rd_entry;

`ifdef WTBUF_COALESCE_EN
    // Shadow of the youngest entry so a merge needs no second read port.
    logic [WordW-1:0]     tail_addr_q, tail_addr_d;
    logic [FE_DATA_W-1:0] tail_data_q, tail_data_d;
    logic [StrbW-1:0]     tail_strb_q, tail_strb_d;
    logic [FE_DATA_W-1:0] merged_data;

    // The tail is only mergeable while it stays in the FIFO this cycle.
    assign merge = wr_valid && (level_q != '0) && !(pop && level_q == LevelW'(1))
                   && (wr_addr == tail_addr_q);

    // Byte-wise merge of the incoming write over the tail entry, plus shadow update.
    always_comb begin
        merged_data = tail_data_q;
        for (int b = 0; b < int'(StrbW); b++) begin
            if (wr_wstrb[b]) begin
                merged_data[b*8 +: 8] = wr_wdata[b*8 +: 8];
            end
        end
        tail_addr_d = tail_addr_q;
        tail_data_d = tail_data_q;
        tail_strb_d = tail_strb_q;
        if (merge) begin
            tail_data_d = merged_data;
            tail_strb_d = tail_strb_q | wr_wstrb;
        end else if (alloc) begin
            tail_addr_d = wr_addr;
            tail_data_d = wr_wdata;
            tail_strb_d = wr_wstrb;
        end
    end

    // Tail shadow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tail_addr_q <= '0;
            tail_data_q <= '0;
            tail_strb_q <= '0;
        end else begin
            tail_addr_q <= tail_addr_d;
            tail_data_q <= tail_data_d;
            tail_strb_q <= tail_strb_d;
        end
    end
`else
    assign merge = 1'b0;
`endif

    assign wr_ready = !full_q || merge;
    assign alloc    = wr_valid && !full_q && !merge;

    // Drain FSM and output registers; pops are decided from registered level only.
    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        unique case (state_q)
            StIdle: begin
                if (level_q != '0) begin
                    pop     = 1'b1;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                if (mem_ready) begin
                    if (level_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        if (pop) begin
            mem_waddr_d = rd_entry[AddrLsb +: WordW];
            mem_wdata_d = rd_entry[DataLsb +: FE_DATA_W];
            mem_wstrb_d = rd_entry[0 +: StrbW];
        end
        mem_valid_d = (state_d == StWrite);
    end

    // Storage write port, pointers, occupancy and status.
    always_comb begin
        ram_we     = alloc;
        ram_wptr   = wr_ptr_q;
        ram_wentry = {wr_addr, wr_wdata, wr_wstrb};
`ifdef WTBUF_COALESCE_EN
        if (merge) begin
            ram_we     = 1'b1;
            ram_wptr   = wr_ptr_q - WTBUF_DEPTH_W'(1);
            ram_wentry = {tail_addr_q, merged_data, tail_strb_q | wr_wstrb};
        end
`endif
        wr_ptr_d = wr_ptr_q + WTBUF_DEPTH_W'(alloc);
        rd_ptr_d = rd_ptr_q + WTBUF_DEPTH_W'(pop);
        level_d  = level_q + LevelW'(alloc) - LevelW'(pop);
        full_d   = (level_d == FullLevel);
        empty_d  = (level_d == '0) && (state_d == StIdle);
    end

    // State registers; reset aborts any in-flight write and discards the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            mem_valid_q <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            mem_valid_q <= mem_valid_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

    write_through_buffer_fifo_mem #(
        .DEPTH_W (WTBUF_DEPTH_W),
        .ENTRY_W (EntryW)
    ) u_fifo_mem (
        .clk      (clk),
        .wr_en    (ram_we),
        .wr_ptr   (ram_wptr),
        .wr_entry (ram_wentry),
        .rd_ptr   (rd_ptr_q),
        .rd_entry (rd_entry)
    );

    assign mem_valid = mem_valid_q;
    assign mem_addr  = {mem_waddr_q, 2'b00};
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign full      = full_q;
    assign empty     = empty_q;
    assign level     = level_q;

endmodule
